xnor_parity_tx: RTL and testbench
=================================

Name: xnor_parity_tx

Overview:
Serial transmitter for the equivalence/parity link. It accepts a parallel word over a valid/ready handshake and serializes it LSB-first, one bit per accepted beat. The serial frame is a start bit, then DATA_W data bits, then one parity bit accumulated through an XNOR/XOR chain. It sits upstream of the serial equivalence checker and drives that checker's bit-stream input.

Parameters:
DATA_W, 8, width of the parallel input word (legal range 2..32)
ODD_PARITY, 1, 1 = parity bit makes the total count of ones in data+parity odd (XNOR accumulation); 0 = even (XOR accumulation)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_W  parallel word to send
valid_in  input  1  data_in is valid
ready_out  output  1  block can accept a word this cycle
tx_bit  output  1  current serial bit
tx_valid  output  1  tx_bit is valid
tx_ready  input  1  sink accepts tx_bit this cycle
tx_last  output  1  current bit is the parity bit (end of frame)
busy  output  1  a frame is in progress

Behaviour:
- Reset is asynchronous, active-high; all outputs are registered. Reset values: ready_out=1, tx_valid=0, tx_bit=1, tx_last=0, busy=0. The shift register, bit counter and parity accumulator clear to 0.
- Input handshake: a word is accepted on a rising edge with valid_in && ready_out. ready_out=1 only in IDLE.
- Output handshake: a serial beat completes on a rising edge with tx_valid && tx_ready. tx_bit, tx_last and the state hold stable while tx_valid && !tx_ready; this is the stall case.
- States and transitions:
  - IDLE: tx_valid=0, tx_bit=1. On accept, latch data_in into the shift register, load the accumulator with ODD_PARITY, clear the counter, and go to START. The next cycle drives tx_valid=1, tx_bit=0. Latency from accept to first valid beat is 1 cycle.
  - START: on beat, go to DATA. tx_bit becomes shreg[0].
  - DATA: on each beat, acc <= acc ^ shreg[0], shift right, counter+1. After beat DATA_W-1, go to PARITY.
  - PARITY: tx_bit = acc (ODD_PARITY=1 gives acc = XNOR-reduce of the data; 0 gives XOR-reduce), tx_last=1. On beat, go to IDLE. ready_out rises the cycle after the parity beat. There are no back-to-back frames without one IDLE cycle.
- A frame occupies DATA_W+2 beats. With tx_ready held high, accept to return-to-IDLE takes DATA_W+3 cycles.
- The counter width is clog2(DATA_W+1) and must not wrap inside a frame.
- valid_in asserted while busy is ignored and is not queued. data_in changing mid-frame has no effect because it was latched at accept.
- If tx_ready is low on the start beat, the bench holds tx_bit=0 indefinitely. There is no timeout.
- rst asserted mid-frame aborts immediately to IDLE with reset values. No partial parity is emitted.
- busy=1 from the cycle after accept through the parity beat.

Decomposition:
- Shared package: state enum {IDLE, START, DATA, PARITY}, START_BIT=0, IDLE_LEVEL=1, and a function that computes the reference parity (XNOR/XOR reduce) for reuse by the checker and the bench.
- One natural sub-module, xnor_parity_acc: a 1-bit accumulator with load and enable, parameterised by ODD_PARITY, so the receiver checker can instantiate the same cell.

Test Plan:
- Reset: rst=1 mid-run → ready_out=1, tx_valid=0, tx_bit=1, busy=0 without waiting for a clock edge.
- Basic frame: DATA_W=8, ODD_PARITY=1, data_in=8'hA5, tx_ready=1 → beats 0, 1,0,1,0,0,1,0,1, then parity 1 (four ones, XNOR=1) with tx_last=1; ready_out returns after 11 cycles.
- Even mode: ODD_PARITY=0, data_in=8'h07 → parity bit 1; data_in=8'h00 → parity bit 0.
- Backpressure: toggle tx_ready randomly during data_in=8'h3C → bit sequence identical to the unstalled run; tx_bit stable on every stall cycle.
- Busy input: valid_in=1 with new data_in=8'hFF during a frame → ignored; the original word completes and ready_out=1 only afterward.
- Abort: rst pulse on data beat 4 → immediate IDLE. The next frame with 8'h81 sends a correct start bit, data and parity of 1.

Source files
------------

// File: rtl/xnor_parity_tx_pkg.sv
// Shared definitions for the equivalence/parity serial link: frame states,
// line levels and a reference parity function for the transmitter and the checker.
package xnor_parity_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    PARITY
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  // odd=1 gives the XNOR-reduce of the low `width` bits, odd=0 the XOR-reduce.
  function automatic logic ref_parity(input logic [31:0] data,
                                      input int unsigned width,
                                      input logic        odd);
    logic        p;
    logic [31:0] d;
    p = odd;
    d = data;
    for (int unsigned i = 0; i < width; i++) begin
      p = p ^ d[0];
      d = d >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/xnor_parity_tx_acc.sv
// One-bit parity accumulator: load seeds it with the parity sense, enable folds in
// one data bit. Shared by the transmitter and the receiving equivalence checker.
module xnor_parity_acc #(
  parameter int unsigned ODD_PARITY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit,
  output logic o_acc
);

  localparam logic LOAD_VAL = (ODD_PARITY != 0);

  logic r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if (i_load) begin
      r_acc <= LOAD_VAL;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_bit;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/xnor_parity_tx.sv
// Serial transmitter: accepts a parallel word and sends start bit, DATA_W data bits
// LSB-first and a parity bit over a valid/ready serial beat interface.
module xnor_parity_tx
  import xnor_parity_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_tx_bit;
  logic              r_tx_valid;
  logic              r_tx_last;
  logic              r_busy;

  logic w_accept;
  logic w_beat;
  logic w_acc;
  logic w_acc_next;

  assign w_accept   = valid_in && r_ready;
  assign w_beat     = r_tx_valid && tx_ready;
  assign w_acc_next = w_acc ^ r_shreg[0];

  xnor_parity_acc #(
    .ODD_PARITY(ODD_PARITY)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_accept),
    .i_en  (w_beat && (r_state == DATA)),
    .i_bit (r_shreg[0]),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_tx_bit   <= IDLE_LEVEL;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= START;
            r_shreg    <= data_in;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_tx_bit   <= START_BIT;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          if (w_beat) begin
            r_state  <= DATA;
            r_tx_bit <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_beat) begin
            r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            // The parity bit is registered from the accumulator's next value so it
            // is on the line the cycle after the final data beat.
            if (r_cnt == LAST_IDX) begin
              r_state   <= PARITY;
              r_tx_bit  <= w_acc_next;
              r_tx_last <= 1'b1;
            end else begin
              r_tx_bit <= r_shreg[1];
            end
          end
        end
        PARITY: begin
          if (w_beat) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_tx_bit   <= IDLE_LEVEL;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = r_ready;
  assign tx_bit    = r_tx_bit;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_xnor_parity_tx.sv
// Directed bench for xnor_parity_tx: odd-parity and even-parity instances driven
// with hand-computed frames, backpressure, busy input and mid-frame reset.
module tb_xnor_parity_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_odd;
  logic       valid_even;
  logic       tx_ready;

  logic ro_o, tb_o, tv_o, tl_o, bz_o;
  logic ro_e, tb_e, tv_e, tl_e, bz_e;

  logic sel;
  logic s_ready, s_bit, s_valid, s_last, s_busy;

  int n_cmp;
  int n_err;

  xnor_parity_tx #(
    .DATA_W    (8),
    .ODD_PARITY(1)
  ) u_odd (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_odd),
    .ready_out(ro_o),
    .tx_bit   (tb_o),
    .tx_valid (tv_o),
    .tx_ready (tx_ready),
    .tx_last  (tl_o),
    .busy     (bz_o)
  );

  xnor_parity_tx #(
    .DATA_W    (8),
    .ODD_PARITY(0)
  ) u_even (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_even),
    .ready_out(ro_e),
    .tx_bit   (tb_e),
    .tx_valid (tv_e),
    .tx_ready (tx_ready),
    .tx_last  (tl_e),
    .busy     (bz_e)
  );

  assign s_ready = sel ? ro_e : ro_o;
  assign s_bit   = sel ? tb_e : tb_o;
  assign s_valid = sel ? tv_e : tv_o;
  assign s_last  = sel ? tl_e : tl_o;
  assign s_busy  = sel ? bz_e : bz_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one word and checks the whole frame; exp_par is the hand-computed parity.
  task automatic run_frame(input logic use_even, input logic [7:0] word, input logic exp_par,
                           input bit stall, input bit hold_ff, input string tag);
    logic beats [16];
    logic lasts [16];
    int   nbeats;
    int   cyc;
    bit   done;
    bit   prev_stall;
    logic prev_bit;
    logic prev_last;
    logic tr;
    sel = use_even;
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(s_ready), 32'd1);
    data_in = word;
    if (use_even) valid_even = 1'b1;
    else valid_odd = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    if (hold_ff) begin
      data_in = 8'hFF;
    end else begin
      valid_odd  = 1'b0;
      valid_even = 1'b0;
    end
    nbeats     = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    prev_last  = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, "_latency_valid"}, 32'(s_valid), 32'd1);
      check({tag, "_busy_mid"}, 32'(s_busy), 32'd1);
      check({tag, "_ready_mid"}, 32'(s_ready), 32'd0);
      if (prev_stall) begin
        check({tag, "_stall_bit"}, 32'(s_bit), 32'(prev_bit));
        check({tag, "_stall_last"}, 32'(s_last), 32'(prev_last));
      end
      tr = stall ? logic'($urandom_range(0, 1)) : 1'b1;
      tx_ready = tr;
      if (s_valid && tr && nbeats < 16) begin
        beats[nbeats] = s_bit;
        lasts[nbeats] = s_last;
        nbeats++;
        if (s_last) done = 1'b1;
      end
      prev_stall = s_valid && !tr;
      prev_bit   = s_bit;
      prev_last  = s_last;
      @(posedge clk);
      cyc++;
    end
    check({tag, "_frame_done"}, 32'(done), 32'd1);
    @(negedge clk);
    valid_odd  = 1'b0;
    valid_even = 1'b0;
    tx_ready   = 1'b1;
    check({tag, "_ready_post"}, 32'(s_ready), 32'd1);
    check({tag, "_busy_post"}, 32'(s_busy), 32'd0);
    check({tag, "_valid_post"}, 32'(s_valid), 32'd0);
    check({tag, "_idle_bit"}, 32'(s_bit), 32'd1);
    if (!stall) check({tag, "_accept_to_idle_cycles"}, 32'(cyc), 32'd11);
    check({tag, "_beat_count"}, 32'(nbeats), 32'd10);
    for (int i = 0; i < nbeats && i < 10; i++) begin
      logic expb;
      if (i == 0) expb = 1'b0;
      else if (i == 9) expb = exp_par;
      else expb = word[i-1];
      check($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(expb));
      check($sformatf("%s_last%0d", tag, i), 32'(lasts[i]), (i == 9) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    sel        = 1'b0;
    rst        = 1'b1;
    data_in    = 8'h00;
    valid_odd  = 1'b0;
    valid_even = 1'b0;
    tx_ready   = 1'b1;

    #1;
    check("rst_ready", 32'(ro_o), 32'd1);
    check("rst_valid", 32'(tv_o), 32'd0);
    check("rst_bit", 32'(tb_o), 32'd1);
    check("rst_last", 32'(tl_o), 32'd0);
    check("rst_busy", 32'(bz_o), 32'd0);
    #11;
    rst = 1'b0;

    // A5: four ones, odd parity bit 1
    run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, "odd_a5");
    // Even mode: 07 has three ones -> 1, 00 -> 0
    run_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, "even_07");
    run_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "even_00");
    // 3C: four ones, odd parity 1, with random backpressure
    run_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, "stall_3c");
    // FF offered while busy must be ignored
    run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, "busy_ff");

    // Mid-frame reset while data beat 4 is on the line
    sel = 1'b0;
    @(negedge clk);
    data_in   = 8'h5A;
    valid_odd = 1'b1;
    @(posedge clk);
    #1;
    valid_odd = 1'b0;
    tx_ready  = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ro_o), 32'd1);
    check("abort_valid", 32'(tv_o), 32'd0);
    check("abort_bit", 32'(tb_o), 32'd1);
    check("abort_last", 32'(tl_o), 32'd0);
    check("abort_busy", 32'(bz_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // 81: two ones, odd parity 1
    run_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b0, "after_abort_81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
